// File: rtl/demod_ctrl.sv
// Bit/byte sequencer for the demodulator: paces bit periods, drives NEW_BYTE,
// assembles MSB-first bytes and hands them downstream over a valid/ready port.
module demod_ctrl #(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned DEF_DIV = 25000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic             demod_out,
    output logic             new_byte,
    output logic             bit_tick,
    output logic [7:0]       byte_data,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             overrun,
    input  logic             clr_ovr,
    output logic             busy
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    logic [DIV_W-1:0]    div_r;
    logic [DIV_W-1:0]    cnt;
    logic [IDX_W-1:0]    bit_idx;
    logic [BYTE_W-2:0]   shift_r;

    logic [DIV_W-1:0]    div_sel_c;
    logic                last_c;
    logic                done_c;
    logic                consume_c;
    logic                drop_c;
    logic [BYTE_W-1:0]   byte_c;

    // Divider selection and per-cycle byte-completion decode
    always_comb begin
        div_sel_c = div_cfg;
        if (div_cfg == '0) begin
            div_sel_c = DIV_W'(DEF_DIV);
        end else if (div_cfg == DIV_W'(1)) begin
            div_sel_c = DIV_W'(2);
        end
        last_c    = (state == RUN) && enable && (cnt == div_r - DIV_W'(1));
        byte_c    = {shift_r, demod_out};
        done_c    = last_c && (bit_idx == IDX_W'(BYTE_W - 1));
        consume_c = byte_valid && byte_ready;
        drop_c    = done_c && byte_valid && !byte_ready;
    end

    // Sequencer FSM; bit_tick/new_byte are computed one cycle ahead so they stay glitch-free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            div_r    <= DIV_W'(DEF_DIV);
            cnt      <= '0;
            bit_idx  <= '0;
            shift_r  <= '0;
            new_byte <= 1'b0;
            bit_tick <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    bit_idx  <= '0;
                    shift_r  <= '0;
                    bit_tick <= 1'b0;
                    if (enable) begin
                        state    <= RUN;
                        div_r    <= div_sel_c;
                        new_byte <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        new_byte <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        bit_idx  <= '0;
                        shift_r  <= '0;
                        new_byte <= 1'b0;
                        bit_tick <= 1'b0;
                        busy     <= 1'b0;
                    end else if (last_c) begin
                        cnt      <= '0;
                        bit_idx  <= IDX_W'(bit_idx + IDX_W'(1));
                        shift_r  <= byte_c[BYTE_W-2:0];
                        new_byte <= (bit_idx == IDX_W'(BYTE_W - 1));
                        bit_tick <= 1'b0;
                    end else begin
                        // div is always >= 2, so div-2 cannot underflow
                        cnt      <= DIV_W'(cnt + DIV_W'(1));
                        bit_tick <= (cnt == div_r - DIV_W'(2));
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output byte register with drop-on-full and sticky overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_data  <= '0;
            byte_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (done_c && (!byte_valid || byte_ready)) begin
                byte_data  <= byte_c;
                byte_valid <= 1'b1;
            end else if (consume_c) begin
                byte_valid <= 1'b0;
            end
            if (clr_ovr) begin
                overrun <= 1'b0;
            end else if (drop_c) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
